dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path (port A) and a DMA/debug host (port B).
- Sits between the execute stage's address/store-data outputs and the data memory block.
- Issues at most one memory access per cycle and routes the 1-cycle-latency read data back to the requester that issued it.
- Fair round-robin arbitration, with bounded burst hold for port B; the CPU stalls while it is not granted.

Parameters:
- DBITS, 32, data and address width.
- DMEMADDRBITS, 13, byte-address bits decoded by the data memory.
- DMEMWORDBITS, 2, byte-offset bits dropped to form the word index.
- MAX_HOLD, 4, maximum consecutive grants to port B while port A is requesting.
- IO_BASE_NIBBLE, 4'hF, value of addr[31:28] that marks memory-mapped I/O; such accesses pass through unchanged.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; state clears on a rising edge of clk while reset==0.
- a_req  in  1  CPU access request (level, held until granted).
- a_we  in  1  CPU write enable.
- a_addr  in  DBITS  CPU byte address.
- a_wdata  in  DBITS  CPU store data.
- a_gnt  out  1  CPU request accepted this cycle (combinational).
- a_rvalid  out  1  CPU read data valid.
- a_rdata  out  DBITS  CPU read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- b_lock  in  1  port B requests burst hold.
- mem_we  out  1  memory write strobe.
- mem_addr  out  DBITS  address presented to the data memory.
- mem_wdata  out  DBITS  write data.
- mem_rdata  in  DBITS  read data, valid one cycle after address.
- stall  out  1  equals a_req & ~a_gnt; drives the PC hold.

Behaviour:
- Reset (reset==0 at a clk edge):
  - last-winner register = B, so A wins first.
  - hold counter = 0.
  - read-return pipeline cleared.
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - Combinational outputs with reset low: all grants 0, mem_we = 0.
  - Reset mid-access: any read in flight is dropped and no rvalid is produced.
- Arbitration (combinational, same cycle):
  - Only one requester: it is granted.
  - Both requesting: the requester that did not win last is granted, unless the lock case below applies.
  - Lock: b_lock is 1, B won last cycle, and hold counter < MAX_HOLD: B is granted again and the counter increments.
  - Counter reset: returns to 0 on any A grant or any cycle where B is not granted.
  - Limit reached: when the counter equals MAX_HOLD and A is requesting, A is granted (forced yield).
  - Neither requesting: no grant, mem_we = 0, mem_addr holds its last value.
- Datapath:
  - mem_addr, mem_wdata and mem_we are muxed from the granted port.
  - mem_we = granted port's we.
- Read return:
  - A granted read (we = 0) pushes the winner ID into a 1-deep return register.
  - Next cycle, the matching rvalid = 1 and rdata = mem_rdata, both registered from mem_rdata at that edge.
  - Back-to-back reads from alternating ports each return one cycle after their own grant; no bubbles.
- Writes produce no rvalid and are committed in the grant cycle.
- Simultaneous read return and a new grant in the same cycle are legal; the return path is independent.
- Invariants: a_gnt and b_gnt are never both 1; a requester dropping req without a grant is legal.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds three output ports:
  - a_grants (32): count of A grants.
  - b_grants (32): count of B grants.
  - conflicts (32): count of cycles with both requesting.
  - All three are cleared on reset and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (dmem_arb_pkg):
  - port-ID constants PORT_A = 1'b0 and PORT_B = 1'b1.
  - DBITS.
  - Address-field widths, reused by the data memory block.
- One sub-module: rr_arb2. It holds the 2-way round-robin with the hold counter and outputs grant vector plus winner ID.
- Muxing and read-return stay in dmem_arbiter.

Test Plan:
- A-only read at 32'h00000100, memory preloaded 32'hDEADBEEF:
  - a_gnt = 1 same cycle; mem_we = 0.
  - Next cycle a_rvalid = 1, a_rdata = 32'hDEADBEEF; b_rvalid = 0.
- A and B both write every cycle after reset:
  - Grants alternate A, B, A, B.
  - stall is 1 on B cycles; memory holds the last written values.
- b_lock = 1 with both requesting continuously, MAX_HOLD = 4:
  - First grant goes to A.
  - Then B is granted on 5 consecutive cycles (1 round-robin grant + 4 hold grants).
  - Then A is granted; the pattern repeats.
- Alternating reads A@0x10 (value 1) and B@0x14 (value 2):
  - Each rvalid fires one cycle after its own grant, with the correct data routed to the correct port.
- Reset driven low for 1 cycle while a B read is in flight:
  - No b_rvalid the next cycle.
  - After reset releases, the first contested grant goes to A.
- With DMEM_ARB_STATS_EN defined, 10 contested cycles: conflicts = 10, a_grants = 5, b_grants = 5.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter and the data memory block:
// port IDs, data width and the byte/word address split.
package dmem_arb_pkg;

   localparam int DBITS         = 32;
   localparam int DMEMADDRBITS  = 13;
   localparam int DMEMWORDBITS  = 2;
   localparam int DMEMINDEXBITS = DMEMADDRBITS - DMEMWORDBITS;

   // addr[31:28] value that marks memory-mapped I/O
   localparam logic [3:0] IO_BASE_NIBBLE = 4'hF;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   function automatic logic [DMEMINDEXBITS-1:0] word_index(input logic [DBITS-1:0] addr);
      return addr[DMEMADDRBITS-1:DMEMWORDBITS];
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with bounded burst hold for requester B.
module rr_arb2
   import dmem_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_req_a,
   input  logic       i_req_b,
   input  logic       i_lock_b,
   output logic [1:0] o_gnt,
   output logic       o_winner,
   output logic       o_valid
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   logic          r_last;
   logic          r_b_prev;
   logic [CW-1:0] r_cnt;
   logic          w_hold;
   logic          w_gnt_a;
   logic          w_gnt_b;

   // Hold needs an actual B grant in the previous cycle, not just r_last == B,
   // so the reset value of r_last alone cannot start a burst.
   always_comb begin
      w_hold  = i_lock_b & r_b_prev & (r_cnt < CW'(MAX_HOLD));
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (i_req_a & i_req_b) begin
         if ((r_last == PORT_A) || w_hold) w_gnt_b = 1'b1;
         else                              w_gnt_a = 1'b1;
      end else begin
         w_gnt_a = i_req_a;
         w_gnt_b = i_req_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last   <= PORT_B;
         r_b_prev <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_b_prev <= w_gnt_b;
         if (w_gnt_a)      r_last <= PORT_A;
         else if (w_gnt_b) r_last <= PORT_B;
         if (w_gnt_b & r_b_prev & i_lock_b)
            r_cnt <= (r_cnt < CW'(MAX_HOLD)) ? r_cnt + CW'(1) : r_cnt;
         else
            r_cnt <= '0;
      end
   end

   assign o_gnt    = {w_gnt_b, w_gnt_a};
   assign o_winner = w_gnt_b ? PORT_B : PORT_A;
   assign o_valid  = w_gnt_a | w_gnt_b;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (A) and a DMA/debug host (B).
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DBITS    = dmem_arb_pkg::DBITS,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [DBITS-1:0] a_addr,
   input  logic [DBITS-1:0] a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [DBITS-1:0] a_rdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [DBITS-1:0] b_addr,
   input  logic [DBITS-1:0] b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [DBITS-1:0] b_rdata,
   input  logic             b_lock,
   output logic             mem_we,
   output logic [DBITS-1:0] mem_addr,
   output logic [DBITS-1:0] mem_wdata,
   input  logic [DBITS-1:0] mem_rdata,
   output logic             stall
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]      a_grants,
   output logic [31:0]      b_grants,
   output logic [31:0]      conflicts
`endif
);

   logic             w_a_req;
   logic             w_b_req;
   logic [1:0]       w_gnt;
   logic             w_winner;
   logic             w_any;
   logic [DBITS-1:0] r_addr_hold;
   logic [DBITS-1:0] r_wdata_hold;
   logic             r_ret_vld_p1;
   logic             r_ret_id_p1;

   // Requests are masked during reset so no grant or write strobe escapes.
   assign w_a_req = a_req & reset;
   assign w_b_req = b_req & reset;

   rr_arb2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req_a  (w_a_req),
      .i_req_b  (w_b_req),
      .i_lock_b (b_lock),
      .o_gnt    (w_gnt),
      .o_winner (w_winner),
      .o_valid  (w_any)
   );

   assign a_gnt = w_gnt[0];
   assign b_gnt = w_gnt[1];
   assign stall = a_req & ~a_gnt;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = r_addr_hold;
      mem_wdata = r_wdata_hold;
      if (a_gnt) begin
         mem_we    = a_we;
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
      end else if (b_gnt) begin
         mem_we    = b_we;
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_any) begin
         r_addr_hold  <= mem_addr;
         r_wdata_hold <= mem_wdata;
      end
   end

   // p0 -> p1: remember who issued a read; memory answers during p1
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ret_vld_p1 <= 1'b0;
         r_ret_id_p1  <= PORT_A;
      end else begin
         r_ret_vld_p1 <= w_any & ~mem_we;
         if (w_any) r_ret_id_p1 <= w_winner;
      end
   end

   assign a_rvalid = reset & r_ret_vld_p1 & (r_ret_id_p1 == PORT_A);
   assign b_rvalid = reset & r_ret_vld_p1 & (r_ret_id_p1 == PORT_B);
   assign a_rdata  = a_rvalid ? mem_rdata : '0;
   assign b_rdata  = b_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] r_a_grants;
   logic [31:0] r_b_grants;
   logic [31:0] r_conflicts;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_a_grants  <= '0;
         r_b_grants  <= '0;
         r_conflicts <= '0;
      end else begin
         if (a_gnt && (r_a_grants != '1))  r_a_grants  <= r_a_grants + 32'd1;
         if (b_gnt && (r_b_grants != '1))  r_b_grants  <= r_b_grants + 32'd1;
         if (w_a_req && w_b_req && (r_conflicts != '1))
            r_conflicts <= r_conflicts + 32'd1;
      end
   end

   assign a_grants  = r_a_grants;
   assign b_grants  = r_b_grants;
   assign conflicts = r_conflicts;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency memory model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
   logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, stall;
   logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] a_grants, b_grants, conflicts;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:2047];
   logic        pre_en = 1'b0;
   logic [10:0] pre_idx = '0;
   logic [31:0] pre_dat = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_dat;
      else if (mem_we) mem[word_index(mem_addr)] <= mem_wdata;
      mem_rdata <= mem[word_index(mem_addr)];
   end

   dmem_arbiter #(.DBITS(32), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .b_lock(b_lock),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
`ifdef DMEM_ARB_STATS_EN
      , .a_grants(a_grants), .b_grants(b_grants), .conflicts(conflicts)
`endif
   );

   task automatic preload(input logic [10:0] idx, input logic [31:0] dat);
      pre_en = 1'b1; pre_idx = idx; pre_dat = dat;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0; b_lock = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
      #1;
      n_checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_gnt: got a=%0b b=%0b want 0 0", a_gnt, b_gnt); end
      n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall: got %0b want 1", stall); end
      @(posedge clk); #1;
      n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got a=%0b b=%0b want 0 0", a_rvalid, b_rvalid); end
      n_checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got a=%h b=%h want 0 0", a_rdata, b_rdata); end
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic test_a_read();
      do_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0100; b_req = 1'b0;
      #1;
      n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_errors++; $display("FAIL a_read_gnt: got a=%0b b=%0b want 1 0", a_gnt, b_gnt); end
      n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h100) begin n_errors++; $display("FAIL a_read_bus: got we=%0b addr=%h want 0 00000100", mem_we, mem_addr); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL a_read_stall: got %0b want 0", stall); end
      @(posedge clk); #1;
      a_req = 1'b0;
      #1;
      n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL a_read_ret: got v=%0b d=%h want 1 deadbeef", a_rvalid, a_rdata); end
      n_checks++; if (b_rvalid !== 1'b0) begin n_errors++; $display("FAIL a_read_b_rvalid: got %0b want 0", b_rvalid); end
      n_checks++; if (a_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin n_errors++; $display("FAIL idle_hold: got gnt=%0b we=%0b addr=%h want 0 0 00000100", a_gnt, mem_we, mem_addr); end
      @(posedge clk); #1;
      n_checks++; if (a_rvalid !== 1'b0) begin n_errors++; $display("FAIL a_read_single: got %0b want 0", a_rvalid); end
   endtask

   task automatic test_alt_writes();
      logic exp_a;
      do_reset();
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
      a_addr = 32'h0000_0200; b_addr = 32'h0000_0204;
      for (int i = 0; i < 4; i++) begin
         a_wdata = 32'hA000_0000 + 32'(i);
         b_wdata = 32'hB000_0000 + 32'(i);
         exp_a = (i % 2 == 0);
         #1;
         n_checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin n_errors++; $display("FAIL wr_gnt[%0d]: got a=%0b b=%0b want %0b %0b", i, a_gnt, b_gnt, exp_a, !exp_a); end
         n_checks++; if (stall !== !exp_a) begin n_errors++; $display("FAIL wr_stall[%0d]: got %0b want %0b", i, stall, !exp_a); end
         n_checks++; if (mem_we !== 1'b1 || mem_addr !== (exp_a ? 32'h200 : 32'h204) || mem_wdata !== (exp_a ? a_wdata : b_wdata))
            begin n_errors++; $display("FAIL wr_bus[%0d]: got we=%0b addr=%h data=%h", i, mem_we, mem_addr, mem_wdata); end
         @(posedge clk); #1;
      end
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
      n_checks++; if (mem[word_index(32'h200)] !== 32'hA000_0002) begin n_errors++; $display("FAIL wr_mem_a: got %h want a0000002", mem[word_index(32'h200)]); end
      n_checks++; if (mem[word_index(32'h204)] !== 32'hB000_0003) begin n_errors++; $display("FAIL wr_mem_b: got %h want b0000003", mem[word_index(32'h204)]); end
   endtask

   task automatic test_lock();
      logic exp_a;
      do_reset();
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1; b_lock = 1'b1;
      a_addr = 32'h0000_0300; b_addr = 32'h0000_0304;
      for (int i = 0; i < 12; i++) begin
         exp_a = (i == 0) || (i == 6);
         #1;
         n_checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin n_errors++; $display("FAIL lock_gnt[%0d]: got a=%0b b=%0b want %0b %0b", i, a_gnt, b_gnt, exp_a, !exp_a); end
         @(posedge clk); #1;
      end
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0; b_lock = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic exp_a, prev_a;
      do_reset();
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
      a_addr = 32'h0000_0010; b_addr = 32'h0000_0014;
      for (int i = 0; i < 6; i++) begin
         exp_a  = (i % 2 == 0);
         prev_a = (i % 2 == 1);
         #1;
         n_checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin n_errors++; $display("FAIL rd_gnt[%0d]: got a=%0b b=%0b want %0b %0b", i, a_gnt, b_gnt, exp_a, !exp_a); end
         if (i == 0) begin
            n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_first[%0d]: got a=%0b b=%0b want 0 0", i, a_rvalid, b_rvalid); end
         end else begin
            n_checks++; if (a_rvalid !== prev_a || b_rvalid !== !prev_a) begin n_errors++; $display("FAIL rd_vld[%0d]: got a=%0b b=%0b want %0b %0b", i, a_rvalid, b_rvalid, prev_a, !prev_a); end
            n_checks++; if (a_rdata !== (prev_a ? 32'd1 : 32'd0) || b_rdata !== (prev_a ? 32'd0 : 32'd2))
               begin n_errors++; $display("FAIL rd_data[%0d]: got a=%h b=%h", i, a_rdata, b_rdata); end
         end
         @(posedge clk); #1;
      end
      a_req = 1'b0; b_req = 1'b0;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0000_0014; a_req = 1'b0;
      #1;
      n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL rif_gnt: got %0b want 1", b_gnt); end
      @(posedge clk); #1;
      reset = 1'b0; b_req = 1'b0;
      #1;
      n_checks++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin n_errors++; $display("FAIL rif_drop: got v=%0b d=%h want 0 0", b_rvalid, b_rdata); end
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      n_checks++; if (b_rvalid !== 1'b0) begin n_errors++; $display("FAIL rif_after: got %0b want 0", b_rvalid); end
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
      a_addr = 32'h0000_0400; b_addr = 32'h0000_0404;
      #1;
      n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_errors++; $display("FAIL rif_first: got a=%0b b=%0b want 1 0", a_gnt, b_gnt); end
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
   endtask

`ifdef DMEM_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      n_checks++; if (conflicts !== 32'd0 || a_grants !== 32'd0) begin n_errors++; $display("FAIL stats_reset: got c=%0d a=%0d want 0 0", conflicts, a_grants); end
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
      a_addr = 32'h0000_0500; b_addr = 32'h0000_0504;
      repeat (10) begin @(posedge clk); #1; end
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (conflicts !== 32'd10) begin n_errors++; $display("FAIL stats_conf: got %0d want 10", conflicts); end
      n_checks++; if (a_grants !== 32'd5 || b_grants !== 32'd5) begin n_errors++; $display("FAIL stats_gnt: got a=%0d b=%0d want 5 5", a_grants, b_grants); end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      preload(11'h040, 32'hDEAD_BEEF);
      preload(11'h004, 32'd1);
      preload(11'h005, 32'd2);
      test_reset();
      test_a_read();
      test_alt_writes();
      test_lock();
      test_back_to_back();
      test_reset_inflight();
`ifdef DMEM_ARB_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
